cordic_xy_arbiter: RTL and testbench
====================================

Name: cordic_xy_arbiter

Overview:
- Shares one X_Y_to_angle CORDIC pipeline among NREQ requesters.
- Each cycle, grants at most one valid request, round-robin, and drives its X/Y into the pipeline.
- Carries a requester tag through a shift register matched to the pipeline latency.
- Routes each returned angle to the requester that issued it.
- Sits between the requester blocks and the X_Y_to_angle instance; it has no arithmetic of its own.

Parameters:
- NREQ, 4, number of requesters (2..8)
- DSIZE, 8, X/Y width; must match the CORDIC instance
- ASIZE, 8, angle width; must match the CORDIC instance
- RNUM, 8, CORDIC iteration count; must match the CORDIC instance
- LAT, RNUM+2, CORDIC latency in clock edges from cordic_x/cordic_y update to the matching cordic_angle
- IDW, 3, tag width; must satisfy 2**IDW >= NREQ

Ports:
- clock, in, 1: single clock, rising edge
- rst, in, 1: reset, asynchronous, active-high
- en, in, 1: issue enable; when low no new grants, in-flight tags still drain
- req_valid, in, NREQ: request valid, one bit per requester
- req_ready, out, NREQ: grant, one-hot or zero; a transfer occurs when req_valid[i] and req_ready[i] are both high at the rising edge
- req_x, in, NREQ*DSIZE: X operands, requester i at bits [i*DSIZE +: DSIZE]
- req_y, in, NREQ*DSIZE: Y operands, same packing as req_x
- cordic_x, out, DSIZE: registered X to the CORDIC
- cordic_y, out, DSIZE: registered Y to the CORDIC
- cordic_angle, in, ASIZE: angle from the CORDIC
- rsp_valid, out, NREQ: registered one-hot response strobe, one cycle wide
- rsp_angle, out, ASIZE: registered angle for the current response
- rsp_id, out, IDW: registered requester index of the current response
- idle, out, 1: high when no tag is in flight and no response is pending

Behaviour:
- Reset (async assert, applied immediately): cordic_x/y=0, rsp_valid=0, rsp_angle=0, rsp_id=0, all tag stages invalid, rr pointer=0, idle=1. req_ready=0 while rst is high.
- Arbitration (combinational from req_valid, en and ptr):
  - Grant the first requester with req_valid high, searching ptr, ptr+1, … NREQ-1, 0, …
  - req_ready is that requester's one-hot bit, or zero if en=0 or no request is valid.
  - No dependence on response state; the block never backpressures on output.
- Issue edge E0 (a grant to requester g):
  - cordic_x<=req_x[g]; cordic_y<=req_y[g].
  - Tag stage 1 <= {valid=1, id=g}.
  - ptr <= (g+1) mod NREQ.
- No grant:
  - cordic_x/y hold their last values.
  - Tag stage 1 <= invalid.
  - ptr holds.
- Tag pipe: LAT stages, shifted every edge unconditionally. Stage k holds the tag issued k edges earlier.
- Response: at each edge, if stage LAT is valid:
  - rsp_valid <= onehot(stage LAT id).
  - rsp_id <= id.
  - rsp_angle <= cordic_angle.
  - Otherwise rsp_valid <= 0, and rsp_angle/rsp_id hold.
  - Net: request accepted at edge E0 gives rsp_valid high in the cycle after edge E0+LAT+1. Default latency RNUM+3 = 11 edges.
- Throughput: one request per cycle sustained, in-order. Responses appear back-to-back in issue order.
- en low mid-stream: issued tags complete normally. idle rises on the edge after the last rsp_valid pulse ends.
- idle = no valid tag stage and rsp_valid == 0.
- Reset mid-operation: all in-flight tags are discarded and no response is produced for them. The first request after reset release is granted to the lowest-index valid requester.
- Requester dropping req_valid without a grant: allowed, no state change.
- NREQ=1: always grants requester 0 when valid and en.

Test Plan:
- Single request: reset, en=1, requester 2 with X=0x80, Y=0x80 for one cycle → req_ready[2] for one cycle; cordic_x/y=0x80 after that edge; rsp_valid=4'b0100, rsp_id=2, rsp_angle equal to the CORDIC model output for (0x80,0x80), exactly 11 edges after issue; idle returns to 1.
- Round-robin fairness: all 4 requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses come back in the same id order on 8 consecutive cycles.
- Pointer skip: after a grant to 1, only requesters 0 and 3 valid → grants 3 then 0.
- en gating: all requesters valid, en low for 5 cycles mid-stream → no req_ready during those cycles; in-flight responses continue; issue resumes at the pointer value held before the gap.
- Reset mid-flight: issue 3 requests, assert rst 4 edges later for 2 cycles → no rsp_valid for those 3 requests; all outputs at reset values; idle=1 during reset.
- Random soak: random req_valid with X,Y in 0..255 for 10k cycles against a scoreboard (per-id FIFO plus CORDIC reference model) → every accepted request gets exactly one response with the correct id and angle, in order, with no extra rsp_valid pulses.

Source files
------------

// File: rtl/cordic_xy_arbiter.sv
// Round-robin front end sharing one X_Y_to_angle CORDIC pipeline among NREQ requesters.
// A tag shift register runs alongside the CORDIC so each angle returns to the requester that issued it.
module cordic_xy_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned DSIZE = 8,
    parameter int unsigned ASIZE = 8,
    parameter int unsigned RNUM  = 8,
    parameter int unsigned LAT   = RNUM + 2,
    parameter int unsigned IDW   = 3
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*DSIZE-1:0] req_x,
    input  logic [NREQ*DSIZE-1:0] req_y,
    output logic [DSIZE-1:0]      cordic_x,
    output logic [DSIZE-1:0]      cordic_y,
    input  logic [ASIZE-1:0]      cordic_angle,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [ASIZE-1:0]      rsp_angle,
    output logic [IDW-1:0]        rsp_id,
    output logic                  idle
);
    // One stage beyond LAT: the angle for an issue at edge E0 is sampled at edge E0+LAT+1.
    localparam int unsigned DEPTH = LAT + 1;
    localparam int unsigned SW    = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [DSIZE-1:0]          x_arr [NREQ];
    logic [DSIZE-1:0]          y_arr [NREQ];
    logic [IDW-1:0]            ptr;
    logic [IDW-1:0]            gid;
    logic                      found;
    logic                      issue;
    int unsigned               scan;
    logic [DEPTH-1:0]          tag_vld;
    logic [DEPTH-1:0][IDW-1:0] tag_id;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign x_arr[i] = req_x[i*DSIZE +: DSIZE];
        assign y_arr[i] = req_y[i*DSIZE +: DSIZE];
    end

    // Round-robin search starting at ptr, wrapping past NREQ-1.
    always_comb begin
        scan  = 0;
        found = 1'b0;
        gid   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan = (32'(ptr) + k) % NREQ;
            if (!found && req_valid[SW'(scan)]) begin
                found = 1'b1;
                gid   = IDW'(scan);
            end
        end
    end

    assign issue     = found && en && !rst;
    assign req_ready = issue ? (NREQ'(1) << gid) : '0;
    assign idle      = (tag_vld == '0) && (rsp_valid == '0);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            cordic_x  <= '0;
            cordic_y  <= '0;
            ptr       <= '0;
            tag_vld   <= '0;
            tag_id    <= '0;
            rsp_valid <= '0;
            rsp_angle <= '0;
            rsp_id    <= '0;
        end else begin
            if (issue) begin
                cordic_x <= x_arr[SW'(gid)];
                cordic_y <= y_arr[SW'(gid)];
                ptr      <= (gid == IDW'(NREQ - 1)) ? '0 : gid + IDW'(1);
            end
            // Tags shift every edge so they stay aligned with the free-running CORDIC.
            tag_vld <= {tag_vld[DEPTH-2:0], issue};
            tag_id  <= {tag_id[DEPTH-2:0], gid};
            if (tag_vld[DEPTH-1]) begin
                rsp_valid <= NREQ'(1) << tag_id[DEPTH-1];
                rsp_id    <= tag_id[DEPTH-1];
                rsp_angle <= cordic_angle;
            end else begin
                rsp_valid <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cordic_xy_arbiter.sv
// Directed and soak bench for cordic_xy_arbiter, with a behavioural CORDIC stand-in of latency LAT.
// The stand-in angle function only needs to differ between operand pairs so misrouting shows up.
module tb_cordic_xy_arbiter;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned DSIZE = 8;
    localparam int unsigned ASIZE = 8;
    localparam int unsigned RNUM  = 8;
    localparam int unsigned LAT   = RNUM + 2;
    localparam int unsigned IDW   = 3;
    localparam int          RSP_EDGES = 11;

    logic                  clock;
    logic                  rst;
    logic                  en;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*DSIZE-1:0] req_x;
    logic [NREQ*DSIZE-1:0] req_y;
    logic [DSIZE-1:0]      cordic_x;
    logic [DSIZE-1:0]      cordic_y;
    logic [ASIZE-1:0]      cordic_angle;
    logic [NREQ-1:0]       rsp_valid;
    logic [ASIZE-1:0]      rsp_angle;
    logic [IDW-1:0]        rsp_id;
    logic                  idle;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit timed_out;

    typedef struct { int cyc; logic [3:0] vec; logic [7:0] x; logic [7:0] y; } grant_t;
    typedef struct { int cyc; logic [3:0] vec; logic [2:0] id; logic [7:0] ang; } rsp_t;
    grant_t grant_log[$];
    rsp_t   rsp_log[$];
    rsp_t   exp_q[$];

    cordic_xy_arbiter #(
        .NREQ(NREQ), .DSIZE(DSIZE), .ASIZE(ASIZE), .RNUM(RNUM), .LAT(LAT), .IDW(IDW)
    ) dut (
        .clock(clock), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .cordic_x(cordic_x), .cordic_y(cordic_y), .cordic_angle(cordic_angle),
        .rsp_valid(rsp_valid), .rsp_angle(rsp_angle), .rsp_id(rsp_id),
        .idle(idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] model_angle(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] t;
        t = 8'(x * 8'd3);
        return t ^ {y[3:0], y[7:4]} ^ 8'h5a;
    endfunction

    // CORDIC stand-in: angle for the current cordic_x/y is visible LAT edges later.
    logic [ASIZE-1:0] cpipe [LAT];
    always @(posedge clock) begin
        cpipe[0] <= model_angle(cordic_x, cordic_y);
        for (int k = 1; k < int'(LAT); k++) cpipe[k] <= cpipe[k-1];
    end
    assign cordic_angle = cpipe[LAT-1];

    // Record every transfer and every response pulse for the tests to inspect.
    always @(negedge clock) begin
        if (!rst && (req_valid & req_ready) != '0) begin
            for (int k = 0; k < int'(NREQ); k++)
                if (req_ready[k])
                    grant_log.push_back('{cyc, req_ready, req_x[k*DSIZE +: DSIZE], req_y[k*DSIZE +: DSIZE]});
        end
        if (rsp_valid != '0) rsp_log.push_back('{cyc, rsp_valid, rsp_id, rsp_angle});
    end

    function automatic int rr_pick(input logic [3:0] v, input int p, input logic e);
        int j;
        if (!e) return -1;
        for (int k = 0; k < 4; k++) begin
            j = (p + k) % 4;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_xy(input int i, input logic [7:0] x, input logic [7:0] y);
        req_x[i*DSIZE +: DSIZE] = x;
        req_y[i*DSIZE +: DSIZE] = y;
    endtask

    task automatic clear_logs();
        grant_log.delete();
        rsp_log.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle();
        timed_out = 1'b1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (idle) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        tick();
        rst       = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req_valid = '1; req_x = '0; req_y = '0;
        @(posedge clock);
        #1;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL reset_idle: got %b want 1", idle); end
        vectors++; if (rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
        vectors++; if ({cordic_x, cordic_y} !== 16'h0000) begin miscompares++; $display("FAIL reset_cordic_xy: got %h want 0000", {cordic_x, cordic_y}); end
        vectors++; if ({rsp_id, rsp_angle} !== 11'h000) begin miscompares++; $display("FAIL reset_rsp_id_angle: got %h want 000", {rsp_id, rsp_angle}); end
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single();
        clear_logs();
        en = 1'b1;
        set_xy(2, 8'h80, 8'h80);
        req_valid = 4'b0100;
        @(negedge clock);
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        vectors++; if ({cordic_x, cordic_y} !== 16'h8080) begin miscompares++; $display("FAIL single_cordic_xy: got %h want 8080", {cordic_x, cordic_y}); end
        vectors++; if (idle !== 1'b0) begin miscompares++; $display("FAIL single_busy: idle got %b want 0", idle); end
        wait_idle();
        vectors++; if (timed_out) begin miscompares++; $display("FAIL single_timeout: idle got 0 want 1 within 40 cycles"); end
        vectors++; if (rsp_log.size() != 1 || grant_log.size() != 1) begin miscompares++; $display("FAIL single_count: rsp %0d grant %0d want 1 1", rsp_log.size(), grant_log.size()); end
        if (rsp_log.size() >= 1 && grant_log.size() >= 1) begin
            vectors++;
            if (rsp_log[0].vec !== 4'b0100 || rsp_log[0].id !== 3'd2 || rsp_log[0].ang !== model_angle(8'h80, 8'h80)) begin
                miscompares++;
                $display("FAIL single_rsp: got vec %b id %0d ang %h want 0100 2 %h", rsp_log[0].vec, rsp_log[0].id, rsp_log[0].ang, model_angle(8'h80, 8'h80));
            end
            vectors++;
            if (rsp_log[0].cyc - grant_log[0].cyc - 1 != RSP_EDGES) begin
                miscompares++;
                $display("FAIL single_latency: got %0d edges want %0d", rsp_log[0].cyc - grant_log[0].cyc - 1, RSP_EDGES);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] expv;
        logic [7:0] ea;
        apply_reset();
        clear_logs();
        en = 1'b1;
        for (int i = 0; i < 4; i++) set_xy(i, 8'(8'h11 * (i + 1)), 8'(8'h30 + i));
        req_valid = '1;
        repeat (8) tick();
        req_valid = '0;
        wait_idle();
        vectors++; if (timed_out) begin miscompares++; $display("FAIL rr_timeout: idle got 0 want 1 within 40 cycles"); end
        vectors++; if (grant_log.size() != 8 || rsp_log.size() != 8) begin miscompares++; $display("FAIL rr_count: grant %0d rsp %0d want 8 8", grant_log.size(), rsp_log.size()); end
        if (grant_log.size() == 8 && rsp_log.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                expv = 4'(1 << (i % 4));
                ea   = model_angle(8'(8'h11 * (i % 4 + 1)), 8'(8'h30 + i % 4));
                vectors++;
                if (grant_log[i].vec !== expv || grant_log[i].cyc - grant_log[0].cyc != i) begin
                    miscompares++;
                    $display("FAIL rr_grant_%0d: got %b at +%0d want %b at +%0d", i, grant_log[i].vec, grant_log[i].cyc - grant_log[0].cyc, expv, i);
                end
                vectors++;
                if (rsp_log[i].id !== 3'(i % 4) || rsp_log[i].ang !== ea || rsp_log[i].cyc != grant_log[i].cyc + 1 + RSP_EDGES) begin
                    miscompares++;
                    $display("FAIL rr_rsp_%0d: got id %0d ang %h cyc %0d want %0d %h %0d", i, rsp_log[i].id, rsp_log[i].ang, rsp_log[i].cyc, i % 4, ea, grant_log[i].cyc + 1 + RSP_EDGES);
                end
            end
        end
    endtask

    task automatic test_pointer_skip();
        int exp_ids [3] = '{1, 3, 0};
        logic [7:0] ea;
        apply_reset();
        clear_logs();
        en = 1'b1;
        for (int i = 0; i < 4; i++) set_xy(i, 8'(8'h40 + i), 8'(8'h07 * i));
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b1001;
        tick();
        tick();
        req_valid = '0;
        wait_idle();
        vectors++; if (timed_out) begin miscompares++; $display("FAIL skip_timeout: idle got 0 want 1 within 40 cycles"); end
        vectors++; if (grant_log.size() != 3 || rsp_log.size() != 3) begin miscompares++; $display("FAIL skip_count: grant %0d rsp %0d want 3 3", grant_log.size(), rsp_log.size()); end
        if (grant_log.size() == 3 && rsp_log.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                ea = model_angle(8'(8'h40 + exp_ids[i]), 8'(8'h07 * exp_ids[i]));
                vectors++;
                if (grant_log[i].vec !== 4'(1 << exp_ids[i]) || rsp_log[i].id !== 3'(exp_ids[i]) || rsp_log[i].ang !== ea) begin
                    miscompares++;
                    $display("FAIL skip_%0d: got grant %b rsp id %0d ang %h want id %0d ang %h", i, grant_log[i].vec, rsp_log[i].id, rsp_log[i].ang, exp_ids[i], ea);
                end
            end
        end
    endtask

    task automatic test_en_gating();
        int exp_ids [5] = '{0, 1, 2, 3, 0};
        int exp_off [5] = '{0, 1, 2, 8, 9};
        logic [7:0] ea;
        apply_reset();
        clear_logs();
        en = 1'b1;
        for (int i = 0; i < 4; i++) set_xy(i, 8'(8'hc0 + i), 8'(8'h0f - i));
        req_valid = '1;
        repeat (3) tick();
        en = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL en_low_%0d: req_ready got %b want 0000", n, req_ready); end
            tick();
        end
        en = 1'b1;
        repeat (2) tick();
        req_valid = '0;
        wait_idle();
        vectors++; if (timed_out) begin miscompares++; $display("FAIL en_timeout: idle got 0 want 1 within 40 cycles"); end
        vectors++; if (grant_log.size() != 5 || rsp_log.size() != 5) begin miscompares++; $display("FAIL en_count: grant %0d rsp %0d want 5 5", grant_log.size(), rsp_log.size()); end
        if (grant_log.size() == 5 && rsp_log.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                ea = model_angle(8'(8'hc0 + exp_ids[i]), 8'(8'h0f - exp_ids[i]));
                vectors++;
                if (grant_log[i].vec !== 4'(1 << exp_ids[i]) || grant_log[i].cyc - grant_log[0].cyc != exp_off[i]) begin
                    miscompares++;
                    $display("FAIL en_grant_%0d: got %b at +%0d want %b at +%0d", i, grant_log[i].vec, grant_log[i].cyc - grant_log[0].cyc, 4'(1 << exp_ids[i]), exp_off[i]);
                end
                vectors++;
                if (rsp_log[i].id !== 3'(exp_ids[i]) || rsp_log[i].ang !== ea || rsp_log[i].cyc != grant_log[i].cyc + 1 + RSP_EDGES) begin
                    miscompares++;
                    $display("FAIL en_rsp_%0d: got id %0d ang %h want id %0d ang %h", i, rsp_log[i].id, rsp_log[i].ang, exp_ids[i], ea);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] ea;
        clear_logs();
        en = 1'b1;
        req_valid = '1;
        repeat (3) tick();
        req_valid = '0;
        repeat (4) tick();
        rst = 1'b1;
        req_valid = '1;
        #1;
        vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL mid_req_ready: got %b want 0000", req_ready); end
        vectors++; if (idle !== 1'b1) begin miscompares++; $display("FAIL mid_idle: got %b want 1", idle); end
        vectors++; if ({cordic_x, cordic_y} !== 16'h0000) begin miscompares++; $display("FAIL mid_cordic_xy: got %h want 0000", {cordic_x, cordic_y}); end
        vectors++; if ({rsp_valid, rsp_id, rsp_angle} !== 15'h0000) begin miscompares++; $display("FAIL mid_rsp: got %h want 0000", {rsp_valid, rsp_id, rsp_angle}); end
        repeat (2) tick();
        vectors++; if (idle !== 1'b1 || rsp_valid !== 4'b0000) begin miscompares++; $display("FAIL mid_hold: idle %b rsp_valid %b want 1 0000", idle, rsp_valid); end
        req_valid = 4'b1100;
        rst = 1'b0;
        @(negedge clock);
        vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL mid_first_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        wait_idle();
        ea = model_angle(8'hc2, 8'h0d);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL mid_timeout: idle got 0 want 1 within 40 cycles"); end
        vectors++; if (rsp_log.size() != 1 || grant_log.size() != 4) begin miscompares++; $display("FAIL mid_count: rsp %0d grant %0d want 1 4", rsp_log.size(), grant_log.size()); end
        if (rsp_log.size() == 1 && grant_log.size() == 4) begin
            vectors++;
            if (rsp_log[0].id !== 3'd2 || rsp_log[0].ang !== ea || rsp_log[0].cyc != grant_log[3].cyc + 1 + RSP_EDGES) begin
                miscompares++;
                $display("FAIL mid_rsp_after: got id %0d ang %h want 2 %h", rsp_log[0].id, rsp_log[0].ang, ea);
            end
        end
    endtask

    task automatic test_soak();
        int ptr_m;
        int pick;
        logic [3:0] expv;
        apply_reset();
        clear_logs();
        ptr_m = 0;
        for (int n = 0; n < 10000; n++) begin
            req_valid = 4'($urandom);
            en = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < 4; i++) set_xy(i, 8'($urandom), 8'($urandom));
            @(negedge clock);
            pick = rr_pick(req_valid, ptr_m, en);
            expv = (pick >= 0) ? 4'(1 << pick) : 4'b0000;
            vectors++;
            if (req_ready !== expv) begin
                miscompares++;
                $display("FAIL soak_grant_%0d: got %b want %b", n, req_ready, expv);
            end
            if (pick >= 0) begin
                exp_q.push_back('{cyc + 1 + RSP_EDGES, expv, 3'(pick),
                                  model_angle(req_x[pick*DSIZE +: DSIZE], req_y[pick*DSIZE +: DSIZE])});
                ptr_m = (pick + 1) % 4;
            end
            tick();
        end
        req_valid = '0;
        wait_idle();
        vectors++; if (timed_out) begin miscompares++; $display("FAIL soak_timeout: idle got 0 want 1 within 40 cycles"); end
        vectors++; if (rsp_log.size() != exp_q.size()) begin miscompares++; $display("FAIL soak_count: got %0d responses want %0d", rsp_log.size(), exp_q.size()); end
        for (int i = 0; i < rsp_log.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (rsp_log[i].cyc != exp_q[i].cyc || rsp_log[i].vec !== exp_q[i].vec ||
                rsp_log[i].id !== exp_q[i].id || rsp_log[i].ang !== exp_q[i].ang) begin
                miscompares++;
                $display("FAIL soak_rsp_%0d: got cyc %0d vec %b id %0d ang %h want cyc %0d vec %b id %0d ang %h", i,
                         rsp_log[i].cyc, rsp_log[i].vec, rsp_log[i].id, rsp_log[i].ang,
                         exp_q[i].cyc, exp_q[i].vec, exp_q[i].id, exp_q[i].ang);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_pointer_skip();
        test_en_gating();
        test_reset_mid();
        test_soak();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
